// File: rtl/nb_result_capture.sv
// Captures upstream (a, c, d) triples into a first-word-fall-through FIFO with sequence tags and drop accounting.
// Optional per-entry "d changed" flag is enabled by defining NB_CAPTURE_DELTA_EN.
module nb_result_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SEQ_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_c,
    input  logic [WIDTH-1:0]         in_d,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_c,
    output logic [WIDTH-1:0]         out_d,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
`ifdef NB_CAPTURE_DELTA_EN
    output logic                     out_dchg,
`endif
    output logic [7:0]               drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             rd_en, wr_en, drop;

    logic [WIDTH-1:0] mem_a_q   [DEPTH];
    logic [WIDTH-1:0] mem_c_q   [DEPTH];
    logic [WIDTH-1:0] mem_d_q   [DEPTH];
    logic [SEQ_W-1:0] mem_seq_q [DEPTH];

`ifdef NB_CAPTURE_DELTA_EN
    logic [WIDTH-1:0] prev_d_q, prev_d_d;
    logic             prev_vld_q, prev_vld_d;
    logic             dchg_new;
    logic             mem_dchg_q [DEPTH];
`endif

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        rd_en      = (level_q != '0) && out_ready;
        wr_en      = in_valid && ((level_q != LVL_W'(DEPTH)) || rd_en);
        drop       = in_valid && !wr_en;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            seq_d    = seq_q + SEQ_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_a_q[wr_ptr_q]   <= in_a;
            mem_c_q[wr_ptr_q]   <= in_c;
            mem_d_q[wr_ptr_q]   <= in_d;
            mem_seq_q[wr_ptr_q] <= seq_q;
        end
    end

`ifdef NB_CAPTURE_DELTA_EN
    always_comb begin
        dchg_new   = !prev_vld_q || (in_d != prev_d_q);
        prev_d_d   = prev_d_q;
        prev_vld_d = prev_vld_q;
        if (wr_en) begin
            prev_d_d   = in_d;
            prev_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_d_q   <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_d_q   <= prev_d_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_dchg_q[wr_ptr_q] <= dchg_new;
        end
    end

    assign out_dchg = mem_dchg_q[rd_ptr_q];
`endif

    assign out_valid = (level_q != '0);
    assign out_a     = mem_a_q[rd_ptr_q];
    assign out_c     = mem_c_q[rd_ptr_q];
    assign out_d     = mem_d_q[rd_ptr_q];
    assign out_seq   = mem_seq_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_nb_result_capture.sv
// Self-checking bench for nb_result_capture: hand-computed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_nb_result_capture;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int SEQ_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [WIDTH-1:0]  in_a, in_c, in_d;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_a, out_c, out_d;
    logic [SEQ_W-1:0]  out_seq;
    logic [$clog2(DEPTH):0] level;
    logic              overflow;
    logic [7:0]        drop_cnt;
`ifdef NB_CAPTURE_DELTA_EN
    logic              out_dchg;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    nb_result_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_c      (in_c),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_seq   (out_seq),
        .level     (level),
        .overflow  (overflow),
`ifdef NB_CAPTURE_DELTA_EN
        .out_dchg  (out_dchg),
`endif
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, c, d;
        logic [7:0]  seq;
        bit          dchg;
    } entry_t;

    typedef struct {
        bit          r, v, rdy;
        logic [31:0] a, c, d;
        bit          ev;
        int          el, es;
        logic [31:0] ea, ec, ed;
        bit          eo;
        int          edr;
    } vec_t;

    // Reference model: an ordered list of stored triples plus plain counters.
    entry_t      mq[$];
    int          m_seq, m_drops;
    bit          m_ovf, m_have_prev;
    logic [31:0] m_prev_d;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [31:0] a, c, d, input bit rdy);
        bit     rd, acc;
        entry_t e;
        if (r) begin
            mq.delete();
            m_seq = 0; m_drops = 0; m_ovf = 0; m_have_prev = 0;
            return;
        end
        rd  = (mq.size() > 0) && rdy;
        acc = v && ((mq.size() < DEPTH) || rd);
        if (rd) void'(mq.pop_front());
        if (acc) begin
            e.a = a; e.c = c; e.d = d;
            e.seq  = 8'(m_seq);
            e.dchg = !m_have_prev || (d != m_prev_d);
            mq.push_back(e);
            m_seq = (m_seq + 1) % 256;
            m_prev_d = d;
            m_have_prev = 1;
        end else if (v) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
        end
    endtask

    task automatic check_output();
        check("valid", 64'(out_valid), 64'(mq.size() != 0));
        check("level", 64'(level), 64'(mq.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        if (mq.size() != 0) begin
            check("head_a", 64'(out_a), 64'(mq[0].a));
            check("head_c", 64'(out_c), 64'(mq[0].c));
            check("head_d", 64'(out_d), 64'(mq[0].d));
            check("head_seq", 64'(out_seq), 64'(mq[0].seq));
`ifdef NB_CAPTURE_DELTA_EN
            check("head_dchg", 64'(out_dchg), 64'(mq[0].dchg));
`endif
        end
    endtask

    // Drive at the falling edge, let the rising edge act, compare at the next falling edge.
    task automatic apply_stimulus(input bit r, input bit v, input logic [31:0] a, c, d, input bit rdy);
        rst = r; in_valid = v; in_a = a; in_c = c; in_d = d; out_ready = rdy;
        @(posedge clk);
        model_edge(r, v, a, c, d, rdy);
        @(negedge clk);
        check_output();
    endtask

    task automatic add_vec(input bit r, v, input logic [31:0] a, c, d, input bit rdy,
                           input bit ev, input int el, es, input logic [31:0] ea, ec, ed,
                           input bit eo, input int edr);
        vec_t x;
        x.r = r; x.v = v; x.a = a; x.c = c; x.d = d; x.rdy = rdy;
        x.ev = ev; x.el = el; x.es = es; x.ea = ea; x.ec = ec; x.ed = ed;
        x.eo = eo; x.edr = edr;
        vecs.push_back(x);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_c = '0; in_d = '0; out_ready = 1'b0;

        // Reset then stream
        add_vec(1,0,  0,  0,  0,0, 0,0,0,   0,  0,  0, 0,0);
        add_vec(1,0,  0,  0,  0,0, 0,0,0,   0,  0,  0, 0,0);
        add_vec(0,1,  0, 15,  5,1, 1,1,0,   0, 15,  5, 0,0);
        add_vec(0,1,  0, 20,  5,1, 1,1,1,   0, 20,  5, 0,0);
        add_vec(0,1,  0, 20,  5,1, 1,1,2,   0, 20,  5, 0,0);
        add_vec(0,0,  0,  0,  0,1, 0,0,0,   0,  0,  0, 0,0);
        // Fill and drop
        add_vec(1,0,  0,  0,  0,0, 0,0,0,   0,  0,  0, 0,0);
        add_vec(0,1,100,200,300,0, 1,1,0, 100,200,300, 0,0);
        add_vec(0,1,101,201,301,0, 1,2,0, 100,200,300, 0,0);
        add_vec(0,1,102,202,302,0, 1,3,0, 100,200,300, 0,0);
        add_vec(0,1,103,203,303,0, 1,4,0, 100,200,300, 0,0);
        add_vec(0,1,104,204,304,0, 1,4,0, 100,200,300, 1,1);
        add_vec(0,1,105,205,305,0, 1,4,0, 100,200,300, 1,2);
        // Full with simultaneous read
        add_vec(0,1,400,500,600,1, 1,4,1, 101,201,301, 1,2);
        add_vec(0,1,401,501,601,1, 1,4,2, 102,202,302, 1,2);
        add_vec(0,1,402,502,602,1, 1,4,3, 103,203,303, 1,2);
        // Drain
        add_vec(0,0,  0,  0,  0,1, 1,3,4, 400,500,600, 1,2);
        add_vec(0,0,  0,  0,  0,1, 1,2,5, 401,501,601, 1,2);
        add_vec(0,0,  0,  0,  0,1, 1,1,6, 402,502,602, 1,2);
        add_vec(0,0,  0,  0,  0,1, 0,0,0,   0,  0,  0, 1,2);
        // Reset mid-operation with level 3 and overflow set
        add_vec(0,1,700,800,900,0, 1,1,7, 700,800,900, 1,2);
        add_vec(0,1,701,801,901,0, 1,2,7, 700,800,900, 1,2);
        add_vec(0,1,702,802,902,0, 1,3,7, 700,800,900, 1,2);
        add_vec(1,1,  1,  2,  3,1, 0,0,0,   0,  0,  0, 0,0);
        add_vec(0,1, 10, 11, 12,0, 1,1,0,  10, 11, 12, 0,0);
        add_vec(0,0,  0,  0,  0,1, 0,0,0,   0,  0,  0, 0,0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].c, vecs[i].d, vecs[i].rdy);
            check("tbl_valid", 64'(out_valid), 64'(vecs[i].ev));
            check("tbl_level", 64'(level), 64'(vecs[i].el));
            check("tbl_overflow", 64'(overflow), 64'(vecs[i].eo));
            check("tbl_drop_cnt", 64'(drop_cnt), 64'(vecs[i].edr));
            if (vecs[i].ev) begin
                check("tbl_seq", 64'(out_seq), 64'(vecs[i].es));
                check("tbl_a", 64'(out_a), 64'(vecs[i].ea));
                check("tbl_c", 64'(out_c), 64'(vecs[i].ec));
                check("tbl_d", 64'(out_d), 64'(vecs[i].ed));
            end
        end

        // Sequence wrap while draining every cycle
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            apply_stimulus(0, 1, $urandom, $urandom, $urandom, 1);
            check("wrap_seq", 64'(out_seq), 64'(i % 256));
        end
        check("wrap_end", 64'(out_seq), 64'd3);

        // Drop counter saturation
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 264; i++) begin
            apply_stimulus(0, 1, $urandom, $urandom, $urandom, 0);
        end
        check("sat_drop_cnt", 64'(drop_cnt), 64'd255);
        check("sat_level", 64'(level), 64'(DEPTH));
        apply_stimulus(0, 0, 0, 0, 0, 1);
        check("sat_head_seq", 64'(out_seq), 64'd1);

`ifdef NB_CAPTURE_DELTA_EN
        begin
            logic [31:0] dseq [5];
            bit          dexp [5];
            dseq = '{32'd5, 32'd5, 32'd7, 32'd7, 32'd5};
            dexp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            apply_stimulus(1, 0, 0, 0, 0, 0);
            for (int i = 0; i < 5; i++) begin
                apply_stimulus(0, 1, 32'(i), 32'(i), dseq[i], 1);
                check("delta_dchg", 64'(out_dchg), 64'(dexp[i]));
            end
        end
`endif

        // Randomized traffic against the reference model
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            apply_stimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                           $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
